// File: rtl/rgb_pkg.sv
// rgb_pkg: colour code and RGB word types shared by the lookup arbiter and the RGB converter
package rgb_pkg;
  localparam int COLOUR_W = 3;
  localparam int RGB_W = 24;
  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [RGB_W-1:0] rgb_t;
  localparam colour_t BLACK = 3'd0;
  localparam colour_t BLUE = 3'd1;
  localparam colour_t GREEN = 3'd2;
  localparam colour_t CYAN = 3'd3;
  localparam colour_t RED = 3'd4;
  localparam colour_t MAGENTA = 3'd5;
  localparam colour_t YELLOW = 3'd6;
  localparam colour_t WHITE = 3'd7;
endpackage

// File: rtl/rgb_lookup_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from the requester after the last grant
module rr_arbiter
  import rgb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack_update,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] last;
  int idx;
  always_comb begin
    grant = '0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last) + k;
      idx = idx >= N ? idx - N : idx;
      if (req[PW'(idx)]) grant = N'(1) << idx;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= PW'(N - 1);
    else if (ack_update)
      for (int i = 0; i < N; i++)
        if (grant[i]) last <= PW'(i);
endmodule

// File: rtl/rgb_lookup_arbiter.sv
// rgb_lookup_arbiter: round-robin sharing of the colour ROM with tagged responses; RGB_ARB_PERF_EN adds grant counters
module rgb_lookup_arbiter
  import rgb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ROM_LAT = 1,
  parameter int ID_W = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [COLOUR_W*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rom_en,
  output logic [COLOUR_W-1:0]       rom_addr,
  input  logic [RGB_W-1:0]          rom_rgb,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RGB_W-1:0]          rsp_rgb
`ifdef RGB_ARB_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [16*N_REQ-1:0]       grant_cnt
`endif
);
  logic [ID_W-1:0] gid;
  logic [ROM_LAT-1:0] pv;
  logic [ID_W-1:0] pid [ROM_LAT];
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .ack_update(rom_en),
    .grant(req_ready)
  );
  assign rom_en = |req_ready;
  always_comb begin
    gid = '0;
    rom_addr = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) begin
        gid = ID_W'(i);
        rom_addr = req_colour[COLOUR_W*i +: COLOUR_W];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < ROM_LAT; i++) pid[i] <= '0;
    end else begin
      pv[0] <= rom_en;
      pid[0] <= gid;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= '0;
      rsp_id <= '0;
      rsp_rgb <= '0;
    end else begin
      rsp_valid <= pv[ROM_LAT-1] ? N_REQ'(1) << pid[ROM_LAT-1] : '0;
      if (pv[ROM_LAT-1]) begin
        rsp_id <= pid[ROM_LAT-1];
        rsp_rgb <= rom_rgb;
      end
    end
`ifdef RGB_ARB_PERF_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    always_ff @(posedge clk or posedge rst)
      if (rst) grant_cnt[16*g +: 16] <= '0;
      else if (perf_clr) grant_cnt[16*g +: 16] <= '0;
      else if (req_valid[g] && req_ready[g] && grant_cnt[16*g +: 16] != 16'hFFFF)
        grant_cnt[16*g +: 16] <= grant_cnt[16*g +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// tb_rgb_lookup_arbiter: randomized and directed checks of both arbiter configurations against a queue-based model
module tb_rgb_lookup_arbiter;
  localparam int N = 2, L = 1, N3 = 3, L3 = 3;
  typedef struct {
    int due;
    int id;
    logic [23:0] rgb;
  } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rv = 0, rr, rspv;
  logic [5:0] rc = 0;
  logic ren, rspid;
  logic [2:0] raddr;
  logic [23:0] rrgb = 0, rsprgb;
  logic [2:0] bv = 0, br, bspv;
  logic [8:0] bc = 0;
  logic ben;
  logic [1:0] bspid;
  logic [2:0] baddr;
  logic [23:0] b0 = 0, b1 = 0, brgb = 0, bsprgb;
`ifdef RGB_ARB_PERF_EN
  logic perf_clr = 0;
  logic [31:0] gcnt;
  logic [47:0] gcnt_b;
`endif
  rgb_lookup_arbiter #(.N_REQ(N), .ROM_LAT(L), .ID_W(1)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_colour(rc), .req_ready(rr),
    .rom_en(ren), .rom_addr(raddr), .rom_rgb(rrgb),
    .rsp_valid(rspv), .rsp_id(rspid), .rsp_rgb(rsprgb)
`ifdef RGB_ARB_PERF_EN
    , .perf_clr(perf_clr), .grant_cnt(gcnt)
`endif
  );
  rgb_lookup_arbiter #(.N_REQ(N3), .ROM_LAT(L3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(bv), .req_colour(bc), .req_ready(br),
    .rom_en(ben), .rom_addr(baddr), .rom_rgb(brgb),
    .rsp_valid(bspv), .rsp_id(bspid), .rsp_rgb(bsprgb)
`ifdef RGB_ARB_PERF_EN
    , .perf_clr(1'b0), .grant_cnt(gcnt_b)
`endif
  );
  always @(posedge clk) if (ren) rrgb <= 24'h0A0000 + 24'(raddr);
  always @(posedge clk) begin
    b0 <= 24'h0A0000 + 24'(baddr);
    b1 <= b0;
    brgb <= b1;
  end
  int total = 0, bad = 0;
  int ptr_a = N - 1, ptr_b = N3 - 1;
  logic [23:0] last_a = 0, last_b = 0;
  exp_t qa[$], qb[$];
  function automatic int pick(input int n, input int last, input logic [7:0] v);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1; rv = 0; bv = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    qa.delete(); qb.delete();
    ptr_a = N - 1; ptr_b = N3 - 1; last_a = 0; last_b = 0;
  endtask
  task automatic tick_a(input logic [1:0] v, input logic [5:0] c, output int g, output logic ev, output exp_t e);
    @(negedge clk);
    rv = v; rc = c;
    #1;
    g = pick(N, ptr_a, {6'b0, v});
    if (g >= 0) begin
      ptr_a = g;
      qa.push_back('{due: cyc + L + 1, id: g, rgb: 24'h0A0000 + 24'(c[3*g +: 3])});
    end
    ev = qa.size() > 0 && qa[0].due == cyc;
    e = '{due: 0, id: 0, rgb: last_a};
    if (ev) begin
      e = qa.pop_front();
      last_a = e.rgb;
    end
  endtask
  task automatic tick_b(input logic [2:0] v, input logic [8:0] c, output int g, output logic ev, output exp_t e);
    @(negedge clk);
    bv = v; bc = c;
    #1;
    g = pick(N3, ptr_b, {5'b0, v});
    if (g >= 0) begin
      ptr_b = g;
      qb.push_back('{due: cyc + L3 + 1, id: g, rgb: 24'h0A0000 + 24'(c[3*g +: 3])});
    end
    ev = qb.size() > 0 && qb[0].due == cyc;
    e = '{due: 0, id: 0, rgb: last_b};
    if (ev) begin
      e = qb.pop_front();
      last_b = e.rgb;
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1; rv = 0; bv = 0;
    #1;
    total++;
    if ({rspv, rspid, rsprgb, rr, ren} !== '0) begin
      bad++;
      $display("FAIL reset_a: got v=%b id=%0d rgb=%h rdy=%b en=%b, want all zero", rspv, rspid, rsprgb, rr, ren);
    end
    total++;
    if ({bspv, bspid, bsprgb, br, ben} !== '0) begin
      bad++;
      $display("FAIL reset_b: got v=%b id=%0d rgb=%h rdy=%b en=%b, want all zero", bspv, bspid, bsprgb, br, ben);
    end
    do_reset();
  endtask
  task automatic test_single();
    int g; logic ev; exp_t e; logic [1:0] v;
    do_reset();
    for (int t = 0; t < 15; t++) begin
      v = t == 10 ? 2'b01 : 2'b00;
      tick_a(v, {3'd0, 3'd5}, g, ev, e);
      total++;
      if ({rr, ren, raddr} !== {g >= 0 ? 2'b01 << g : 2'b00, g >= 0, g >= 0 ? 3'd5 : 3'd0}) begin
        bad++;
        $display("FAIL single_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d", t, rr, ren, raddr, g);
      end
      total++;
      if ({rspv, rsprgb} !== {ev ? 2'b01 << e.id : 2'b00, e.rgb} || (ev && rspid !== 1'(e.id))) begin
        bad++;
        $display("FAIL single_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, rspv, rspid, rsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
  task automatic test_alternate();
    int g; logic ev; exp_t e;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      tick_a(t < 6 ? 2'b11 : 2'b00, {3'd7, 3'd2}, g, ev, e);
      total++;
      if ({rr, ren, raddr} !== {g >= 0 ? 2'b01 << g : 2'b00, g >= 0, g == 1 ? 3'd7 : 3'd2 & {3{g == 0}}}) begin
        bad++;
        $display("FAIL alt_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d", t, rr, ren, raddr, g);
      end
      total++;
      if ({rspv, rsprgb} !== {ev ? 2'b01 << e.id : 2'b00, e.rgb} || (ev && rspid !== 1'(e.id))) begin
        bad++;
        $display("FAIL alt_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, rspv, rspid, rsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
  task automatic test_stream();
    int g; logic ev; exp_t e; logic [2:0] col;
    for (int t = 0; t < 11; t++) begin
      col = 3'(t);
      tick_a(t < 8 ? 2'b10 : 2'b00, {col, 3'd0}, g, ev, e);
      total++;
      if ({rr, ren, raddr} !== {g >= 0 ? 2'b01 << g : 2'b00, g >= 0, g >= 0 ? col : 3'd0}) begin
        bad++;
        $display("FAIL stream_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d addr %0d", t, rr, ren, raddr, g, col);
      end
      total++;
      if ({rspv, rsprgb} !== {ev ? 2'b01 << e.id : 2'b00, e.rgb} || (ev && rspid !== 1'(e.id))) begin
        bad++;
        $display("FAIL stream_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, rspv, rspid, rsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
  task automatic test_rst_mid();
    int g; logic ev; exp_t e;
    tick_a(2'b10, {3'd3, 3'd0}, g, ev, e);
    tick_a(2'b01, {3'd0, 3'd6}, g, ev, e);
    @(negedge clk);
    rst = 1; rv = 0;
    #1;
    total++;
    if ({rspv, rspid, rsprgb, rr, ren} !== '0) begin
      bad++;
      $display("FAIL rst_mid_out: got v=%b id=%0d rgb=%h rdy=%b en=%b, want all zero", rspv, rspid, rsprgb, rr, ren);
    end
    @(negedge clk);
    rst = 0;
    qa.delete(); ptr_a = N - 1; last_a = 0;
    for (int t = 0; t < 7; t++) begin
      tick_a(t == 3 ? 2'b11 : 2'b00, {3'd1, 3'd4}, g, ev, e);
      total++;
      if ({rr, ren, raddr} !== {g >= 0 ? 2'b01 << g : 2'b00, g >= 0, g >= 0 ? 3'd4 : 3'd0}) begin
        bad++;
        $display("FAIL rst_mid_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d", t, rr, ren, raddr, g);
      end
      total++;
      if ({rspv, rsprgb} !== {ev ? 2'b01 << e.id : 2'b00, e.rgb} || (ev && rspid !== 1'(e.id))) begin
        bad++;
        $display("FAIL rst_mid_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, rspv, rspid, rsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
  task automatic test_random();
    int g; logic ev; exp_t e;
    logic [1:0] v, pend;
    logic [5:0] c;
    pend = 0; c = 0;
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          c[3*i +: 3] = 3'($urandom_range(0, 7));
        end else v[i] = $urandom_range(0, 7) != 0;
      if (t >= 295) v = 0;
      tick_a(v, c, g, ev, e);
      for (int i = 0; i < N; i++) pend[i] = v[i] && g != i;
      total++;
      if ({rr, ren, raddr} !== {g >= 0 ? 2'b01 << g : 2'b00, g >= 0, g >= 0 ? c[3*g +: 3] : 3'd0}) begin
        bad++;
        $display("FAIL rand_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d", t, rr, ren, raddr, g);
      end
      total++;
      if ({rspv, rsprgb} !== {ev ? 2'b01 << e.id : 2'b00, e.rgb} || (ev && rspid !== 1'(e.id))) begin
        bad++;
        $display("FAIL rand_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, rspv, rspid, rsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
  task automatic test_lat3();
    int g; logic ev; exp_t e; logic [8:0] c;
    do_reset();
    c = 9'($urandom);
    for (int t = 0; t < 20; t++) begin
      tick_b(t < 12 ? 3'b111 : 3'b000, c, g, ev, e);
      total++;
      if ({br, ben, baddr} !== {g >= 0 ? 3'b001 << g : 3'b000, g >= 0, g >= 0 ? c[3*g +: 3] : 3'd0}) begin
        bad++;
        $display("FAIL lat3_issue t=%0d: got rdy=%b en=%b addr=%0d, want grant %0d", t, br, ben, baddr, g);
      end
      total++;
      if ({bspv, bsprgb} !== {ev ? 3'b001 << e.id : 3'b000, e.rgb} || (ev && bspid !== 2'(e.id))) begin
        bad++;
        $display("FAIL lat3_rsp t=%0d: got v=%b id=%0d rgb=%h, want v=%0d id=%0d rgb=%h", t, bspv, bspid, bsprgb, ev, e.id, e.rgb);
      end
    end
  endtask
`ifdef RGB_ARB_PERF_EN
  task automatic test_perf();
    int g; logic ev; exp_t e;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      tick_a(2'b01, {3'd0, 3'd1}, g, ev, e);
      total++;
      if (gcnt[15:0] !== 16'(t)) begin
        bad++;
        $display("FAIL perf_inc t=%0d: got %0d, want %0d", t, gcnt[15:0], t);
      end
    end
    tick_a(2'b01, {3'd0, 3'd1}, g, ev, e);
    perf_clr = 1;
    total++;
    if (gcnt[15:0] !== 16'd5) begin
      bad++;
      $display("FAIL perf_before_clr: got %0d, want 5", gcnt[15:0]);
    end
    tick_a(2'b00, 6'd0, g, ev, e);
    perf_clr = 0;
    total++;
    if (gcnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_after_clr: got %h, want 0", gcnt);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stream();
    test_rst_mid();
    test_random();
    test_lat3();
`ifdef RGB_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
